// File: rtl/udp_img_pkg.sv
// Shared constants and types for the UDP image-line depacketizer.
package udp_img_pkg;

  // Required value of header bits [31:16]
  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

  // Header field positions within the first payload word
  localparam int unsigned MAGIC_HI = 31;
  localparam int unsigned MAGIC_LO = 16;
  localparam int unsigned LINE_HI  = 11;
  localparam int unsigned LINE_LO  = 0;

  // Line geometry for the default 640-pixel line
  localparam int unsigned IMG_W_DEF  = 640;
  localparam int unsigned LINE_BYTES = 4 + 2 * IMG_W_DEF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPix  = 2'd1,
    StDrop = 2'd2
  } state_e;

  // Expected payload length of a well-formed line packet: header word plus RGB565 pixels
  function automatic logic [15:0] line_bytes(input int unsigned img_w);
    return 16'(4 + 2 * img_w);
  endfunction

endpackage

// File: rtl/udp_img_ser32to16.sv
// Two-entry word-to-halfword serializer: a loaded word leaves as its high half on the next
// cycle and its low half on the cycle after. A load while the low half is pending replaces it.
module udp_img_ser32to16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] word,
  output logic        valid,
  output logic [15:0] data,
  output logic        busy
);

  logic [15:0] data_q;
  logic [15:0] lo_q;
  logic        valid_q;
  logic        pend_q;

  // Present the high half after a load, then drain the stored low half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      lo_q    <= '0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
    end else if (load) begin
      data_q  <= word[31:16];
      lo_q    <= word[15:0];
      valid_q <= 1'b1;
      pend_q  <= 1'b1;
    end else if (pend_q) begin
      data_q  <= lo_q;
      valid_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign busy  = pend_q;

endmodule

// File: rtl/udp_img_depack.sv
// Parses one image line per UDP packet (header word + RGB565 pixels) into a pixel stream with
// coordinates and line/frame markers; malformed packets are dropped and counted.
module udp_img_depack #(
  parameter int unsigned IMG_W     = 640,
  parameter int unsigned IMG_H     = 480,
  parameter logic [15:0] HDR_MAGIC = udp_img_pkg::HDR_MAGIC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rec_en,
  input  logic [31:0] rec_data,
  input  logic        rec_pkt_done,
  input  logic [15:0] rec_byte_num,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_sol,
  output logic        pix_eol,
  output logic        frame_start,
  output logic        frame_done,
  output logic        pkt_err,
  output logic        seq_err,
  output logic [15:0] drop_cnt
);

  import udp_img_pkg::*;

  localparam logic [11:0] WLim       = 12'(IMG_W);
  localparam logic [11:0] WLast      = 12'(IMG_W - 1);
  localparam logic [11:0] HLim       = 12'(IMG_H);
  localparam logic [11:0] HLast      = 12'(IMG_H - 1);
  localparam logic [15:0] LineBytesW = line_bytes(IMG_W);

  state_e      state_q;
  logic [11:0] line_q;
  logic [11:0] exp_q;
  logic [11:0] cnt_q;
  logic        fin_q;
  logic        pkt_err_q;
  logic        seq_err_q;
  logic        frame_done_q;
  logic [15:0] drop_q;

  logic [15:0] hdr_magic;
  logic [11:0] hdr_line;
  logic        hdr_ok;
  logic        ser_load;
  logic        ser_valid;
  logic [15:0] ser_data;
  logic        ser_busy;
  logic        pix_valid_w;
  logic        pix_sol_w;
  logic        pix_eol_w;

  // Header decode and pixel-stream qualification
  always_comb begin
    hdr_magic   = rec_data[MAGIC_HI:MAGIC_LO];
    hdr_line    = rec_data[LINE_HI:LINE_LO];
    hdr_ok      = (hdr_magic == HDR_MAGIC) && (hdr_line < HLim);
    ser_load    = rec_en && (state_q == StPix);
    // Surplus pixels beyond the line width never become visible
    pix_valid_w = ser_valid && (cnt_q < WLim);
    pix_sol_w   = pix_valid_w && (cnt_q == '0);
    pix_eol_w   = pix_valid_w && (cnt_q == WLast);
  end

  udp_img_ser32to16 u_ser (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ser_load),
    .word  (rec_data),
    .valid (ser_valid),
    .data  (ser_data),
    .busy  (ser_busy)
  );

  // Packet FSM, line/sequence tracking, pixel counter and error strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      line_q       <= '0;
      exp_q        <= '0;
      cnt_q        <= '0;
      fin_q        <= 1'b0;
      pkt_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= '0;
    end else begin
      pkt_err_q    <= 1'b0;
      seq_err_q    <= 1'b0;
      frame_done_q <= pix_eol_w && (line_q == HLast);
      if (pix_valid_w) begin
        cnt_q <= cnt_q + 12'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (rec_en) begin
            if (hdr_ok && !rec_pkt_done) begin
              state_q   <= StPix;
              line_q    <= hdr_line;
              cnt_q     <= '0;
              seq_err_q <= (hdr_line != exp_q);
              exp_q     <= (hdr_line == HLast) ? 12'd0 : hdr_line + 12'd1;
            end else begin
              // Bad header, or a packet too short to carry any pixel
              pkt_err_q <= 1'b1;
              if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
              end
              if (!rec_pkt_done) begin
                state_q <= StDrop;
              end
            end
          end
        end
        StPix: begin
          if (rec_en && rec_pkt_done) begin
            fin_q     <= 1'b1;
            pkt_err_q <= (rec_byte_num != LineBytesW);
          end
          // Leave only once the last loaded word has fully drained
          if (fin_q && !ser_busy) begin
            state_q <= StIdle;
            fin_q   <= 1'b0;
          end
        end
        StDrop: begin
          if (rec_en && rec_pkt_done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pix_valid   = pix_valid_w;
  assign pix_data    = ser_data;
  assign pix_x       = cnt_q;
  assign pix_y       = line_q;
  assign pix_sol     = pix_sol_w;
  assign pix_eol     = pix_eol_w;
  assign frame_start = pix_sol_w && (line_q == '0);
  assign frame_done  = frame_done_q;
  assign pkt_err     = pkt_err_q;
  assign seq_err     = seq_err_q;
  assign drop_cnt    = drop_q;

endmodule
